l1_refill_arbiter: RTL
======================

Name: l1_refill_arbiter

Overview:
- Shares the single L2 read port between the L1 instruction-cache refill path and the L1 data-cache refill path.
- Each L1 miss handler raises a request with a block address. The arbiter picks one requester round-robin, drives the L2 read interface, holds the grant until L2 returns the 256-bit block, registers the block, and pulses a per-requester done.
- Sits between the fetch/memory-stage caches and the L2.

Parameters:
- ADDR_W, 32, address width.
- BLOCK_W, 256, refill block width in bits.
- OFFSET_BITS, 5, block-offset bits cleared on the L2 address.
- CNT_W, 16, width of the saturating per-requester refill counters.

Ports:
- clk  in  1  core clock.
- rst_n  in  1  asynchronous, active-low reset.
- ic_req  in  1  icache refill request; held high until ic_done.
- ic_addr  in  ADDR_W  icache miss address; stable while ic_req is high.
- ic_done  out  1  one-cycle pulse; resp_block holds the icache block.
- dc_req  in  1  dcache refill request; held high until dc_done.
- dc_addr  in  ADDR_W  dcache miss address; stable while dc_req is high.
- dc_done  out  1  one-cycle pulse; resp_block holds the dcache block.
- resp_block  out  BLOCK_W  registered refill data.
- l2_read_en  out  1  L2 read request.
- l2_addr_read  out  ADDR_W  L2 block address, low OFFSET_BITS forced to 0.
- l2_block_read  in  BLOCK_W  L2 data; valid when l2_read_en=1 and l2_stall=0.
- l2_stall  in  1  high while L2 is waiting on main memory.
- busy  out  1  high in any state other than IDLE.
- ic_refills  out  CNT_W  completed icache refills, saturating.
- dc_refills  out  CNT_W  completed dcache refills, saturating.

Behaviour:
- Reset values (async, all outputs): state IDLE, l2_read_en=0, l2_addr_read=0, ic_done=0, dc_done=0, resp_block=0, busy=0, counters=0, rr_ptr=0 (icache preferred).
- States: IDLE, REQ, DONE.
- IDLE:
  - Only one request high: grant that requester.
  - Both high: grant the requester selected by rr_ptr (0=icache, 1=dcache).
  - On grant, next cycle: latch {addr[ADDR_W-1:OFFSET_BITS], 0} into l2_addr_read, set l2_read_en=1, record the granted id, enter REQ.
  - No request: remain in IDLE.
- REQ:
  - l2_read_en stays high and l2_addr_read stays constant.
  - Each cycle with l2_stall=0: capture l2_block_read into resp_block, drop l2_read_en, pulse the granted id's done, enter DONE.
  - Each cycle with l2_stall=1: stay in REQ; no timeout.
- DONE:
  - Lasts exactly one cycle; done is high only here.
  - rr_ptr is set to the non-granted requester.
  - The granted counter increments, saturating at all-ones.
  - Next state is IDLE.
- Requester rule: sample done at the clock edge ending the DONE cycle and deassert req from the following cycle. The arbiter never re-grants a requester off the DONE cycle itself.
- Latency: request seen in IDLE at cycle T.
  - l2_read_en is high from T+1.
  - If L2 hits at T+1, done is high at T+2.
  - Minimum request-to-done is 2 cycles; each stall cycle adds 1.
- resp_block holds its value until the next capture.
- Simultaneous events:
  - A request arriving during REQ or DONE waits; it is never dropped.
  - A held request is granted no later than after one refill of the other requester (starvation-free).
- ic_done and dc_done are never high together.
- A request dropped before grant is not serviced. Dropping a request after grant is illegal; the arbiter completes the L2 read and still pulses done.
- Reset mid-REQ: immediately deassert l2_read_en and return to IDLE; the in-flight L2 data is discarded.
- Address bits [OFFSET_BITS-1:0] are ignored.

Test Plan:
- Reset, then ic_req=1 with ic_addr=0x0000_1234 and l2_stall=0 -> l2_read_en=1 and l2_addr_read=0x0000_1220 at T+1; ic_done=1 and resp_block equal to the L2 data at T+2; ic_refills=1.
- dc_req with dc_addr=0x8000_0040 and l2_stall held high for 5 cycles -> l2_read_en high for 6 cycles, l2_addr_read constant at 0x8000_0040, dc_done only after stall falls, ic_done stays 0.
- ic_req and dc_req both held continuously -> grants alternate IC, DC, IC, DC; done pulses are never coincident; each refill takes 3 cycles including DONE.
- dc_req asserted during an icache REQ with stall -> dc_done follows ic_done by 3 cycles with L2 zero-stall; dc_addr is not issued while the icache read is outstanding.
- rst_n pulled low mid-REQ -> l2_read_en=0 and busy=0 asynchronously; after release, a re-raised request is serviced from IDLE with correct latency.
- Counter preloaded by running 2^CNT_W refills (or CNT_W=4 in the bench) -> ic_refills saturates at all-ones and does not wrap.

Source files
------------

// File: rtl/l1_refill_arbiter_if.sv
// Refill bus between the two L1 miss handlers, the arbiter and the L2 read port.
// The arbiter takes the slave view; the caches/L2 side (or a bench) takes the master view.
interface l1_refill_arbiter_if #(
    parameter int ADDR_W  = 32,
    parameter int BLOCK_W = 256,
    parameter int CNT_W   = 16
);
    // icache refill requester
    logic               ic_req;
    logic [ADDR_W-1:0]  ic_addr;
    logic               ic_done;
    // dcache refill requester
    logic               dc_req;
    logic [ADDR_W-1:0]  dc_addr;
    logic               dc_done;
    // returned block shared by both requesters
    logic [BLOCK_W-1:0] resp_block;
    // L2 read port
    logic               l2_read_en;
    logic [ADDR_W-1:0]  l2_addr_read;
    logic [BLOCK_W-1:0] l2_block_read;
    logic               l2_stall;
    // status
    logic               busy;
    logic [CNT_W-1:0]   ic_refills;
    logic [CNT_W-1:0]   dc_refills;

    modport slave (
        input  ic_req, ic_addr, dc_req, dc_addr, l2_block_read, l2_stall,
        output ic_done, dc_done, resp_block, l2_read_en, l2_addr_read,
               busy, ic_refills, dc_refills
    );

    modport master (
        output ic_req, ic_addr, dc_req, dc_addr, l2_block_read, l2_stall,
        input  ic_done, dc_done, resp_block, l2_read_en, l2_addr_read,
               busy, ic_refills, dc_refills
    );
endinterface

// File: rtl/l1_refill_arbiter.sv
// L1 refill arbiter: shares one L2 read port between the icache and dcache
// refill paths. Round-robin grant, grant held until L2 returns the block,
// block registered into resp_block, one-cycle done pulse to the winner.
module l1_refill_arbiter #(
    parameter int ADDR_W      = 32,
    parameter int BLOCK_W     = 256,
    parameter int OFFSET_BITS = 5,
    parameter int CNT_W       = 16
) (
    input  logic               clk,
    input  logic               rst_n,
    l1_refill_arbiter_if.slave bus
);

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_REQ  = 2'd1,
        ST_DONE = 2'd2
    } state_t;

    // Requester ids: 0 = icache, 1 = dcache.
    state_t             state_r;
    logic               rr_ptr_r;
    logic               gnt_id_r;
    logic               l2_read_en_r;
    logic [ADDR_W-1:0]  l2_addr_r;
    logic               ic_done_r;
    logic               dc_done_r;
    logic [BLOCK_W-1:0] resp_block_r;
    logic               busy_r;
    logic [CNT_W-1:0]   ic_cnt_r;
    logic [CNT_W-1:0]   dc_cnt_r;

    logic               grant_valid_s;
    logic               grant_dc_s;
    logic [ADDR_W-1:0]  grant_addr_s;

    // Clear the block-offset bits so L2 always sees a block-aligned address.
    function automatic logic [ADDR_W-1:0] block_align(input logic [ADDR_W-1:0] addr);
        block_align = {addr[ADDR_W-1:OFFSET_BITS], {OFFSET_BITS{1'b0}}};
    endfunction

    // Increment that sticks at all-ones instead of wrapping.
    function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] cnt);
        if (cnt == {CNT_W{1'b1}}) begin
            sat_inc = cnt;
        end else begin
            sat_inc = cnt + {{(CNT_W-1){1'b0}}, 1'b1};
        end
    endfunction

    // Pick the requester to grant when idle: a lone request wins, a tie goes to rr_ptr.
    always_comb begin
        grant_valid_s = 1'b0;
        grant_dc_s    = 1'b0;
        grant_addr_s  = {ADDR_W{1'b0}};
        if (bus.ic_req && bus.dc_req) begin
            grant_valid_s = 1'b1;
            grant_dc_s    = rr_ptr_r;
        end else if (bus.ic_req) begin
            grant_valid_s = 1'b1;
            grant_dc_s    = 1'b0;
        end else if (bus.dc_req) begin
            grant_valid_s = 1'b1;
            grant_dc_s    = 1'b1;
        end else begin
            grant_valid_s = 1'b0;
            grant_dc_s    = 1'b0;
        end
        if (grant_dc_s) begin
            grant_addr_s = block_align(bus.dc_addr);
        end else begin
            grant_addr_s = block_align(bus.ic_addr);
        end
    end

    // Refill FSM with all outputs registered; reset aborts any in-flight L2 read.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_r      <= ST_IDLE;
            rr_ptr_r     <= 1'b0;
            gnt_id_r     <= 1'b0;
            l2_read_en_r <= 1'b0;
            l2_addr_r    <= {ADDR_W{1'b0}};
            ic_done_r    <= 1'b0;
            dc_done_r    <= 1'b0;
            resp_block_r <= {BLOCK_W{1'b0}};
            busy_r       <= 1'b0;
            ic_cnt_r     <= {CNT_W{1'b0}};
            dc_cnt_r     <= {CNT_W{1'b0}};
        end else begin
            case (state_r)
                ST_IDLE: begin
                    ic_done_r <= 1'b0;
                    dc_done_r <= 1'b0;
                    if (grant_valid_s) begin
                        state_r      <= ST_REQ;
                        l2_read_en_r <= 1'b1;
                        l2_addr_r    <= grant_addr_s;
                        gnt_id_r     <= grant_dc_s;
                        busy_r       <= 1'b1;
                    end else begin
                        state_r      <= ST_IDLE;
                        l2_read_en_r <= 1'b0;
                        busy_r       <= 1'b0;
                    end
                end
                ST_REQ: begin
                    // Address and read enable hold steady for as long as L2 stalls.
                    if (!bus.l2_stall) begin
                        state_r      <= ST_DONE;
                        l2_read_en_r <= 1'b0;
                        resp_block_r <= bus.l2_block_read;
                        ic_done_r    <= ~gnt_id_r;
                        dc_done_r    <= gnt_id_r;
                        // Hand priority to the other requester so a waiting one cannot starve.
                        rr_ptr_r     <= ~gnt_id_r;
                        if (gnt_id_r) begin
                            dc_cnt_r <= sat_inc(dc_cnt_r);
                        end else begin
                            ic_cnt_r <= sat_inc(ic_cnt_r);
                        end
                    end else begin
                        state_r      <= ST_REQ;
                        l2_read_en_r <= 1'b1;
                    end
                end
                ST_DONE: begin
                    // Requests are ignored here so the winner is never re-granted off its own done.
                    state_r      <= ST_IDLE;
                    l2_read_en_r <= 1'b0;
                    ic_done_r    <= 1'b0;
                    dc_done_r    <= 1'b0;
                    busy_r       <= 1'b0;
                end
                default: begin
                    state_r      <= ST_IDLE;
                    l2_read_en_r <= 1'b0;
                    ic_done_r    <= 1'b0;
                    dc_done_r    <= 1'b0;
                    busy_r       <= 1'b0;
                end
            endcase
        end
    end

    assign bus.l2_read_en   = l2_read_en_r;
    assign bus.l2_addr_read = l2_addr_r;
    assign bus.ic_done      = ic_done_r;
    assign bus.dc_done      = dc_done_r;
    assign bus.resp_block   = resp_block_r;
    assign bus.busy         = busy_r;
    assign bus.ic_refills   = ic_cnt_r;
    assign bus.dc_refills   = dc_cnt_r;

endmodule
